// File: rtl/pulse_stretch_if.sv
// pulse_stretch_if: event-in / stretched-level-out bundle for pulse_stretch.
// Signals: pulse_in (event strobe), level_out (stretched level), busy (HOLD or GAP),
//   pending (queued events, PEND_W bits), overflow (sticky drop flag).
// Modports: master drives pulse_in and observes status; slave is the stretcher itself.
interface pulse_stretch_if #(
   parameter int PEND_W = 3
);
   logic              pulse_in;
   logic              level_out;
   logic              busy;
   logic [PEND_W-1:0] pending;
   logic              overflow;
   modport master (output pulse_in, input level_out, busy, pending, overflow);
   modport slave (input pulse_in, output level_out, busy, pending, overflow);
endinterface

// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle event pulses into HOLD_CYCLES-high levels, each followed by a GAP_CYCLES low gap.
// Ports: clk; rst_n (async, active-low); bus (pulse_stretch_if.slave):
//   pulse_in in, level_out/busy/pending/overflow out, all registered.
// Option: define PULSE_STRETCH_QUEUE_EN to queue pulses arriving while busy in a
//   saturating pending counter; otherwise such pulses are dropped and pending is 0.
module pulse_stretch #(
   parameter int HOLD_CYCLES = 4096,
   parameter int GAP_CYCLES  = 1024,
   parameter int PEND_W      = 3
) (
   input logic            clk,
   input logic            rst_n,
   pulse_stretch_if.slave bus
);
   localparam int MAX_C = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW = MAX_C > 1 ? $clog2(MAX_C) : 1;
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          level_q, level_d;
   logic          busy_q, busy_d;
   logic          gap_end;
   logic          restart;
   assign gap_end = (state_q == GAP) && (cnt_q == '0);
   assign level_d = state_d == HOLD;
   assign busy_d  = state_d != IDLE;
`ifdef PULSE_STRETCH_QUEUE_EN
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              pend_full;
   logic              busy_pulse;
   assign pend_full  = &pend_q;
   // a pulse on the last gap cycle starts the next hold itself, so it is never queued
   assign busy_pulse = bus.pulse_in && (state_q != IDLE) && !gap_end;
   assign restart    = (pend_q != '0) || bus.pulse_in;
   // queued event takes the start slot; a same-cycle arrival replaces it in the queue
   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (gap_end)
         pend_d = (pend_q != '0 && !bus.pulse_in) ? pend_q - 1'b1 : pend_q;
      else if (busy_pulse) begin
         pend_d = pend_full ? pend_q : pend_q + 1'b1;
         ovf_d  = ovf_q | pend_full;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pend_q <= '0;
      else pend_q <= pend_d;
   assign bus.pending = pend_q;
`else
   assign restart     = 1'b0;
   assign ovf_d       = ovf_q | (bus.pulse_in && (state_q != IDLE));
   assign bus.pending = {PEND_W{1'b0}};
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - 1'b1;
      unique case (state_q)
         IDLE: begin
            state_d = bus.pulse_in ? HOLD : IDLE;
            cnt_d   = bus.pulse_in ? HOLD_LD : cnt_q;
         end
         HOLD: if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = GAP_LD;
         end
         GAP: if (gap_end) begin
            state_d = restart ? HOLD : IDLE;
            cnt_d   = restart ? HOLD_LD : '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         level_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         level_q <= level_d;
         busy_q  <= busy_d;
      end
   assign bus.level_out = level_q;
   assign bus.busy      = busy_q;
   assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: random and directed stimulus checked every cycle against a timestamp-based model.
module tb_pulse_stretch;
   localparam int H = 4;
   localparam int G = 2;
   localparam int PW = 2;
   localparam int PMAX = 3;
`ifdef PULSE_STRETCH_QUEUE_EN
   localparam bit QEN = 1'b1;
`else
   localparam bit QEN = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   pulse_stretch_if #(.PEND_W(PW)) bus ();
   pulse_stretch #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .PEND_W(PW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );
   // model: s is the edge at which the current hold began; everything else follows from t-s
   int t = 0;
   int s = -1000;
   int m_pend = 0;
   bit m_ovf = 1'b0;
   bit prev_lvl = 1'b0;
   int total = 0;
   int bad = 0;
   int rises[$];
   int r, hi, bz, pmax_seen;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at edge %0d: got %0h want %0h", n, t, act, exp);
      end
   endtask
   task automatic model_edge(input bit p);
      int e;
      bit bsy;
      e = t - 1 - s;
      bsy = (e >= 0) && (e < H + G);
      if (!bsy) begin
         if (p) s = t;
      end else if (e == H + G - 1 && (m_pend > 0 || (QEN && p))) begin
         s = t;
         if (m_pend > 0 && !p) m_pend--;
      end else if (p) begin
         if (QEN && m_pend < PMAX) m_pend++;
         else m_ovf = 1'b1;
      end
   endtask
   task automatic compare();
      int e;
      e = t - s;
      chk("level_out", 32'(bus.level_out), 32'(e >= 0 && e < H));
      chk("busy", 32'(bus.busy), 32'(e >= 0 && e < H + G));
      chk("pending", 32'(bus.pending), m_pend);
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      if (bus.level_out && !prev_lvl) rises.push_back(t);
      prev_lvl = bus.level_out;
      if (int'(bus.pending) > pmax_seen) pmax_seen = int'(bus.pending);
   endtask
   task automatic step(input bit p);
      bus.pulse_in = p;
      @(posedge clk);
      t++;
      #1;
      model_edge(p);
      compare();
   endtask
   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      bus.pulse_in = 1'b0;
      #1;
      s = -1000;
      m_pend = 0;
      m_ovf = 1'b0;
      prev_lvl = 1'b0;
      chk("rst_level", 32'(bus.level_out), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_pending", 32'(bus.pending), 0);
      chk("rst_overflow", 32'(bus.overflow), 0);
      repeat (2) begin
         @(posedge clk);
         t++;
      end
      #1;
      rst_n = 1'b1;
      rises.delete();
      pmax_seen = 0;
   endtask
   initial begin
      bus.pulse_in = 1'b0;
      @(posedge clk);
      t++;
      do_reset();
      repeat (3) step(1'b0);
      // single pulse
      r = t;
      step(1'b1);
      hi = int'(bus.level_out);
      bz = int'(bus.busy);
      repeat (10) begin
         step(1'b0);
         hi += int'(bus.level_out);
         bz += int'(bus.busy);
      end
      chk("single_rises", rises.size(), 1);
      if (rises.size() > 0) chk("single_rise_edge", rises[0] - r, 1);
      chk("single_hold_len", hi, H);
      chk("single_busy_len", bz, H + G);
`ifdef PULSE_STRETCH_QUEUE_EN
      // queued pulses
      do_reset();
      repeat (3) step(1'b0);
      r = t;
      step(1'b1);
      step(1'b0);
      step(1'b1);
      step(1'b1);
      chk("queue_pend2", 32'(bus.pending), 2);
      repeat (20) step(1'b0);
      chk("queue_rises", rises.size(), 3);
      if (rises.size() == 3) begin
         chk("queue_rise0", rises[0] - r, 1);
         chk("queue_rise1", rises[1] - r, 7);
         chk("queue_rise2", rises[2] - r, 13);
      end
      chk("queue_ovf", 32'(bus.overflow), 0);
      // saturation
      do_reset();
      repeat (2) step(1'b0);
      repeat (5) step(1'b1);
      chk("sat_ovf", 32'(bus.overflow), 1);
      repeat (40) step(1'b0);
      chk("sat_pend_max", pmax_seen, 3);
      chk("sat_rises", rises.size(), 4);
      // simultaneous arrival and dequeue
      do_reset();
      repeat (2) step(1'b0);
      step(1'b1);
      step(1'b1);
      repeat (4) step(1'b0);
      step(1'b1);
      chk("simul_pend", 32'(bus.pending), 1);
      chk("simul_level", 32'(bus.level_out), 1);
      repeat (20) step(1'b0);
      chk("simul_rises", rises.size(), 3);
`else
      // queue compiled out
      do_reset();
      repeat (2) step(1'b0);
      r = t;
      step(1'b1);
      step(1'b0);
      step(1'b1);
      chk("noq_ovf", 32'(bus.overflow), 1);
      chk("noq_pend", 32'(bus.pending), 0);
      repeat (4) step(1'b0);
      step(1'b1);
      repeat (8) step(1'b0);
      chk("noq_rises", rises.size(), 2);
      if (rises.size() == 2) begin
         chk("noq_rise0", rises[0] - r, 1);
         chk("noq_rise1", rises[1] - r, 8);
      end
`endif
      // reset mid-hold, then a full hold afterwards
      do_reset();
      step(1'b0);
      step(1'b1);
      repeat (2) step(1'b0);
      chk("midhold_level", 32'(bus.level_out), 1);
      do_reset();
      step(1'b1);
      hi = int'(bus.level_out);
      repeat (10) begin
         step(1'b0);
         hi += int'(bus.level_out);
      end
      chk("post_reset_hold_len", hi, H);
      // random traffic at several densities with occasional resets
      foreach (rises[i]) rises[i] = 0;
      for (int b = 0; b < 4; b++) begin
         int pct;
         pct = (b == 0) ? 5 : (b == 1) ? 25 : (b == 2) ? 60 : 95;
         do_reset();
         for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            step($urandom_range(0, 99) < pct);
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
